// File: rtl/arp_decode_pkg.sv
// Shared ARP constants, field offsets and decoder state type, used by the
// ARP decoder and encoder.
package arp_pkg;

    localparam logic [15:0] ARP_HTYPE        = 16'h0001;
    localparam logic [15:0] ARP_PTYPE        = 16'h0800;
    localparam logic [7:0]  ARP_HLEN         = 8'h06;
    localparam logic [7:0]  ARP_PLEN         = 8'h04;
    localparam logic [15:0] ARP_OPER_REQUEST = 16'h0001;
    localparam logic [15:0] ARP_OPER_REPLY   = 16'h0002;

    localparam logic [4:0] OFF_HTYPE = 5'd0;
    localparam logic [4:0] OFF_PTYPE = 5'd2;
    localparam logic [4:0] OFF_HLEN  = 5'd4;
    localparam logic [4:0] OFF_PLEN  = 5'd5;
    localparam logic [4:0] OFF_OPER  = 5'd6;
    localparam logic [4:0] OFF_SHA   = 5'd8;
    localparam logic [4:0] OFF_SPA   = 5'd14;
    localparam logic [4:0] OFF_THA   = 5'd18;
    localparam logic [4:0] OFF_TPA   = 5'd24;
    localparam logic [5:0] ARP_LEN   = 6'd28;
    localparam logic [4:0] OFF_LAST  = 5'(ARP_LEN - 6'd1);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_HDR,
        ST_SHA,
        ST_SPA,
        ST_THA,
        ST_TPA,
        ST_PAD,
        ST_DISCARD
    } arp_dec_state_t;

    // Expected request header byte at offsets 0..7.
    function automatic logic [7:0] hdr_byte(input logic [2:0] idx);
        case (idx)
            3'd0:    return ARP_HTYPE[15:8];
            3'd1:    return ARP_HTYPE[7:0];
            3'd2:    return ARP_PTYPE[15:8];
            3'd3:    return ARP_PTYPE[7:0];
            3'd4:    return ARP_HLEN;
            3'd5:    return ARP_PLEN;
            3'd6:    return ARP_OPER_REQUEST[15:8];
            default: return ARP_OPER_REQUEST[7:0];
        endcase
    endfunction

    // Parse state that owns the byte at payload offset off.
    function automatic arp_dec_state_t state_for(input logic [4:0] off);
        if (off < OFF_SHA)      return ST_HDR;
        else if (off < OFF_SPA) return ST_SHA;
        else if (off < OFF_THA) return ST_SPA;
        else if (off < OFF_TPA) return ST_THA;
        else                    return ST_TPA;
    endfunction

endpackage

// File: rtl/arp_decode_if.sv
// Byte-serial ARP payload input and decoded-request result bundle.
interface arp_decode_if;
    logic        ivalid;
    logic [7:0]  din;
    logic        req_valid;
    logic [47:0] sha;
    logic [31:0] spa;
    logic        drop;

    modport master (output ivalid, din, input req_valid, sha, spa, drop);
    modport slave  (input ivalid, din, output req_valid, sha, spa, drop);
endinterface

// File: rtl/arp_decode.sv
// Byte-serial ARP request decoder: accepts requests targeting IP_ADDR and
// reports the sender address pair, or pulses drop on any rejected frame.
module arp_decode
    import arp_pkg::*;
#(
    parameter logic [47:0] MAC_ADDR = 48'h0,
    parameter logic [31:0] IP_ADDR  = 32'h0
) (
    input logic        clk,
    input logic        rst,
    arp_decode_if.slave bus
);

    arp_dec_state_t state_q, state_d;
    logic [4:0]  cnt_q, cnt_d;
    logic        mism_q, mism_d;
    logic [47:0] sha_st_q, sha_st_d, sha_q, sha_d;
    logic [31:0] spa_st_q, spa_st_d, spa_q, spa_d;
    logic        req_q, req_d, drop_q, drop_d;

    logic       in_frame, take, hdr_bad, tpa_bad, last, trunc;
    logic [4:0] off;
    logic [7:0] ip_byte;

    // IDLE consumes the first byte of a frame as offset 0.
    assign in_frame = state_q inside {ST_HDR, ST_SHA, ST_SPA, ST_THA, ST_TPA};
    assign take     = bus.ivalid && (state_q == ST_IDLE || in_frame);
    assign off      = (state_q == ST_IDLE) ? '0 : cnt_q;
    assign trunc    = in_frame && !bus.ivalid;
    assign last     = take && (off == OFF_LAST);

    always_comb begin
        case (off[1:0])
            2'd0:    ip_byte = IP_ADDR[31:24];
            2'd1:    ip_byte = IP_ADDR[23:16];
            2'd2:    ip_byte = IP_ADDR[15:8];
            default: ip_byte = IP_ADDR[7:0];
        endcase
    end

    assign hdr_bad = take && (off < OFF_SHA) && (bus.din != hdr_byte(off[2:0]));
    assign tpa_bad = take && (off >= OFF_TPA) && (bus.din != ip_byte);

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q  <= ST_IDLE;
            cnt_q    <= '0;
            mism_q   <= 1'b0;
            sha_st_q <= '0;
            spa_st_q <= '0;
            sha_q    <= '0;
            spa_q    <= '0;
            req_q    <= 1'b0;
            drop_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            mism_q   <= mism_d;
            sha_st_q <= sha_st_d;
            spa_st_q <= spa_st_d;
            sha_q    <= sha_d;
            spa_q    <= spa_d;
            req_q    <= req_d;
            drop_q   <= drop_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        if (trunc) begin
            state_d = ST_IDLE;
            cnt_d   = '0;
        end else if (hdr_bad) begin
            state_d = ST_DISCARD;
            cnt_d   = '0;
        end else if (last) begin
            state_d = ST_PAD;
            cnt_d   = '0;
        end else if (take) begin
            state_d = state_for(off + 5'd1);
            cnt_d   = off + 5'd1;
        end else if ((state_q == ST_PAD || state_q == ST_DISCARD) && !bus.ivalid) begin
            state_d = ST_IDLE;
        end
    end

    always_comb begin
        drop_d   = trunc || hdr_bad || (last && (mism_q || tpa_bad));
        req_d    = last && !mism_q && !tpa_bad;
        mism_d   = ((state_q == ST_IDLE) ? 1'b0 : mism_q) || tpa_bad;
        sha_st_d = sha_st_q;
        spa_st_d = spa_st_q;
        if (take && off >= OFF_SHA && off < OFF_SPA) sha_st_d = {sha_st_q[39:0], bus.din};
        if (take && off >= OFF_SPA && off < OFF_THA) spa_st_d = {spa_st_q[23:0], bus.din};
        // SPA staging is complete long before offset 27, so the pair is coherent.
        sha_d    = req_d ? sha_st_q : sha_q;
        spa_d    = req_d ? spa_st_q : spa_q;
    end

    assign bus.req_valid = req_q;
    assign bus.drop      = drop_q;
    assign bus.sha       = sha_q;
    assign bus.spa       = spa_q;

endmodule

// File: tb/tb_arp_decode.sv
// Randomized and directed self-checking bench for arp_decode against a
// frame-level reference model.
module tb_arp_decode;

    localparam logic [47:0] MAC = 48'h02_00_00_00_00_01;
    localparam logic [31:0] IP  = 32'hC0A8_0102;

    logic clk = 1'b0;
    logic rst;
    arp_decode_if bus ();

    arp_decode #(.MAC_ADDR(MAC), .IP_ADDR(IP)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int unsigned n_chk  = 0;
    int unsigned n_pass = 0;

    logic        e_req, e_drop;
    logic [47:0] e_sha;
    logic [31:0] e_spa;
    logic [7:0]  rx_q[$];
    logic        decided;
    logic [7:0]  hdr_ref [8] = '{8'h00, 8'h01, 8'h08, 8'h00, 8'h06, 8'h04, 8'h00, 8'h01};
    logic [7:0]  frm [28];

    task automatic chk(input string tag, input logic [47:0] obs, input logic [47:0] exp);
        n_chk++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
    endtask

    // Frame-level model: bytes of the current frame collected in a queue,
    // verdict taken on the first bad header byte, at byte 27, or on truncation.
    task automatic model();
        int unsigned idx;
        logic [31:0] tpa;
        e_req  = 1'b0;
        e_drop = 1'b0;
        if (!rst) begin
            rx_q.delete();
            decided = 1'b0;
            e_sha   = '0;
            e_spa   = '0;
        end else if (bus.ivalid) begin
            if (!decided) begin
                rx_q.push_back(bus.din);
                idx = rx_q.size() - 1;
                if (idx < 8 && bus.din != hdr_ref[idx]) begin
                    e_drop  = 1'b1;
                    decided = 1'b1;
                end else if (idx == 27) begin
                    tpa = {rx_q[24], rx_q[25], rx_q[26], rx_q[27]};
                    if (tpa == IP) begin
                        e_req = 1'b1;
                        e_sha = {rx_q[8], rx_q[9], rx_q[10], rx_q[11], rx_q[12], rx_q[13]};
                        e_spa = {rx_q[14], rx_q[15], rx_q[16], rx_q[17]};
                    end else begin
                        e_drop = 1'b1;
                    end
                    decided = 1'b1;
                end
            end
        end else begin
            if (rx_q.size() > 0 && !decided) e_drop = 1'b1;
            rx_q.delete();
            decided = 1'b0;
        end
    endtask

    task automatic step(input logic r, input logic v, input logic [7:0] d);
        @(negedge clk);
        chk("req_valid", {47'b0, bus.req_valid}, {47'b0, e_req});
        chk("drop", {47'b0, bus.drop}, {47'b0, e_drop});
        chk("excl", {47'b0, bus.req_valid & bus.drop}, 48'h0);
        chk("sha", bus.sha, e_sha);
        chk("spa", {16'b0, bus.spa}, {16'b0, e_spa});
        rst        = r;
        bus.ivalid = v;
        bus.din    = d;
        model();
    endtask

    task automatic make_frame(input logic [15:0] oper, input logic [47:0] sha,
                              input logic [31:0] spa, input logic [31:0] tpa);
        logic [63:0] hdr;
        hdr = {16'h0001, 16'h0800, 8'h06, 8'h04, oper};
        for (int i = 0; i < 8; i++) frm[i] = hdr[63-8*i -: 8];
        for (int i = 0; i < 6; i++) frm[8+i] = sha[47-8*i -: 8];
        for (int i = 0; i < 4; i++) frm[14+i] = spa[31-8*i -: 8];
        for (int i = 0; i < 6; i++) frm[18+i] = 8'h00;
        for (int i = 0; i < 4; i++) frm[24+i] = tpa[31-8*i -: 8];
    endtask

    // Send the first n bytes, optional reset on byte rst_at, then pad bytes and gap idles.
    task automatic send(input int n, input int pad, input int gap, input int rst_at);
        for (int i = 0; i < n; i++) step((i == rst_at) ? 1'b0 : 1'b1, 1'b1, frm[i]);
        for (int i = 0; i < pad; i++) step(1'b1, 1'b1, 8'($urandom));
        for (int i = 0; i < gap; i++) step(1'b1, 1'b0, 8'h00);
    endtask

    initial begin
        rst        = 1'b0;
        bus.ivalid = 1'b0;
        bus.din    = 8'h00;
        decided    = 1'b0;
        model();
        step(1'b0, 1'b0, 8'h00);
        step(1'b1, 1'b0, 8'h00);

        make_frame(16'h0001, 48'hAABB_CCDD_EEFF, 32'hC0A8_0101, 32'hC0A8_0102);
        send(28, 0, 1, -1);
        make_frame(16'h0001, 48'h1122_3344_5566, 32'hC0A8_0105, 32'hC0A8_0103);
        send(28, 0, 1, -1);
        make_frame(16'h0002, 48'h1122_3344_5566, 32'hC0A8_0105, 32'hC0A8_0102);
        send(28, 18, 2, -1);
        make_frame(16'h0001, 48'h0102_0304_0506, 32'h0A00_0001, 32'hC0A8_0102);
        send(16, 0, 1, -1);
        send(28, 0, 1, -1);
        make_frame(16'h0001, 48'hAABB_CCDD_EEFF, 32'hC0A8_0101, 32'hC0A8_0102);
        send(28, 0, 1, 10);
        send(28, 0, 1, -1);
        make_frame(16'h0001, 48'h0A0B_0C0D_0E0F, 32'hC0A8_0109, 32'hC0A8_0102);
        send(28, 0, 1, -1);

        for (int f = 0; f < 60; f++) begin
            int unsigned kind;
            logic [31:0] tpa;
            int n;
            kind = $urandom_range(0, 9);
            tpa  = (kind == 1) ? $urandom : IP;
            make_frame((kind == 2) ? 16'h0002 : 16'h0001,
                       {$urandom, $urandom} , $urandom, tpa);
            if (kind == 3) frm[$urandom_range(0, 7)] ^= 8'(1 << $urandom_range(0, 7));
            if (kind == 4) frm[$urandom_range(24, 27)] ^= 8'h01;
            if (kind == 5) for (int i = 18; i < 24; i++) frm[i] = 8'hFF;
            n = (kind == 6) ? $urandom_range(1, 27) : 28;
            send(n, (n == 28) ? $urandom_range(0, 20) : 0, $urandom_range(1, 3),
                 (kind == 7) ? $urandom_range(0, 27) : -1);
        end
        step(1'b1, 1'b0, 8'h00);
        step(1'b1, 1'b0, 8'h00);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/arp_decode.md
ARP_DECODE -- requirements
Module: arp_decode

Interface
REQ-001 SHALL have parameter MAC_ADDR, default 48'h0, local station hardware address.
REQ-002 SHALL have parameter IP_ADDR, default 32'h0, local station IPv4 address; requests whose TPA matches it are accepted.
REQ-003 clk  input  1  sole clock; all logic on rising edge.
REQ-004 rst  input  1  reset, synchronous, active-low (rst=0 resets).
REQ-005 ivalid  input  1  din carries an ARP payload byte this cycle; high for the whole payload and low between frames.
REQ-006 din  input  8  payload byte, network order; first byte is HTYPE MSB.
REQ-007 req_valid  output  1  one-cycle pulse: valid ARP request for IP_ADDR decoded.
REQ-008 sha  output  48  sender hardware address of accepted request; held until next accept.
REQ-009 spa  output  32  sender protocol address of accepted request; held until next accept.
REQ-010 drop  output  1  one-cycle pulse: frame rejected (bad header, wrong opcode, TPA mismatch, or truncation).

Function
REQ-011 SHALL parse byte-serial, one byte per ivalid cycle, offsets: HTYPE 0-1, PTYPE 2-3, HLEN 4, PLEN 5, OPER 6-7, SHA 8-13, SPA 14-17, THA 18-23, TPA 24-27.
REQ-012 SHALL implement states IDLE, HDR (bytes 0-7), SHA, SPA, THA, TPA, PAD, DISCARD.
REQ-013 IDLE -> HDR on first ivalid=1 byte, consuming it as offset 0; byte counter 0-27, 5 bits, never wraps past 27.
REQ-014 HDR checks each byte on arrival: HTYPE=16'h0001, PTYPE=16'h0800, HLEN=8'h06, PLEN=8'h04, OPER=16'h0001; first mismatch pulses drop the next cycle and enters DISCARD.
REQ-015 SHA and SPA bytes SHALL shift MSB-first into internal staging registers; sha/spa outputs change only on accept.
REQ-016 THA bytes are consumed and ignored (broadcast or zero THA is legal).
REQ-017 TPA bytes are compared against IP_ADDR byte by byte; a single mismatch marks the frame rejected but parsing continues to offset 27.
REQ-018 After offset 27 sampled at cycle N: at N+1 either req_valid=1 with sha/spa updated (TPA match) or drop=1 (mismatch); state -> PAD.
REQ-019 PAD and DISCARD ignore bytes (Ethernet padding/FCS) until ivalid=0, then -> IDLE; req_valid/drop never repeat within one frame.
REQ-020 ivalid=0 before offset 27 (truncation) SHALL pulse drop the next cycle and -> IDLE; no req_valid.
REQ-021 ivalid=0 in IDLE, PAD or DISCARD produces no pulse.
REQ-022 req_valid and drop SHALL never both be high; at most one of them per frame.
REQ-023 A frame starting the cycle after ivalid falls (one-cycle gap) SHALL be parsed normally from IDLE.
REQ-024 sha/spa SHALL form a coherent pair from one frame; a later rejected frame leaves them unchanged.

Reset
REQ-025 rst=0 at a rising edge SHALL force IDLE, counter 0, req_valid=0, drop=0, sha=48'h0, spa=32'h0, staging registers 0.
REQ-026 Reset mid-frame SHALL abandon the frame without a pulse; after release, the remaining bytes of that frame (ivalid still high) are parsed as a new frame starting at offset 0 and ultimately rejected (drop).

Structure
REQ-027 ARP constants (HTYPE 16'h0001, PTYPE 16'h0800, HLEN 6, PLEN 4, OPER_REQUEST 1, OPER_REPLY 2, field offsets, payload length 28) SHALL live in shared package arp_pkg, also used by the encoder.
REQ-028 State enum arp_dec_state_t SHALL live in arp_pkg.
REQ-029 Single module, no sub-modules; sha/spa output registers written only on accept.

Verification
REQ-030 MAC_ADDR=48'h02_00_00_00_00_01, IP_ADDR=32'hC0A8_0102; request SHA 48'hAABB_CCDD_EEFF, SPA 32'hC0A8_0101, TPA 32'hC0A8_0102, 28 back-to-back bytes -> req_valid one cycle after byte 27, sha=48'hAABBCCDDEEFF, spa=32'hC0A80101, no drop.
REQ-031 Same frame with TPA 32'hC0A8_0103 -> drop one cycle after byte 27, no req_valid, sha/spa keep previous values.
REQ-032 OPER=16'h0002 (reply) -> drop one cycle after byte 7, following 20 bytes plus 18 padding bytes produce no further pulse.
REQ-033 ivalid deasserted after byte 15 -> drop next cycle, IDLE; immediate valid request frame after 1-cycle gap -> req_valid.
REQ-034 rst=0 for one cycle at byte 10 of a valid request, ivalid held high -> no req_valid, outputs zero, drop pulses when remainder fails HTYPE check.
REQ-035 Two valid requests separated by 1 idle cycle with different SHA -> two req_valid pulses, sha tracks each.
